// File: rtl/multicycle_ctrl.sv
// Main sequencer of the multicycle datapath: steps each instruction through
// IDLE/FETCH/DECODE/EXEC/MEM/WB and drives the register WriteEns, the memory
// request handshake and the datapath mux selects.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       op_class,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             ir_we,
  output logic             ab_we,
  output logic             aluout_we,
  output logic             mdr_we,
  output logic             rf_we,
  output logic             wb_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    ERR    = 3'd7
  } state_t;

  localparam logic [2:0] OP_ALUR   = 3'd0;
  localparam logic [2:0] OP_ALUI   = 3'd1;
  localparam logic [2:0] OP_LOAD   = 3'd2;
  localparam logic [2:0] OP_STORE  = 3'd3;
  localparam logic [2:0] OP_BRANCH = 3'd4;
  localparam logic [2:0] OP_JUMP   = 3'd5;
  localparam logic [2:0] OP_HALT   = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  // Wide enough to hold MEM_TIMEOUT itself.
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t             stateReg;
  state_t             stateNext;
  logic [2:0]         opReg;
  logic [WAIT_W-1:0]  waitCnt;
  logic [CNT_W-1:0]   retiredReg;
  logic               timeoutHit;

  // This stalled cycle is the MEM_TIMEOUT-th one; a same-cycle mem_ready still wins.
  assign timeoutHit = (waitCnt == WAIT_W'(MEM_TIMEOUT - 1)) && !mem_ready;

  // Next-state and combinational control outputs; everything defaults to 0.
  always_comb begin
    stateNext = stateReg;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    ir_we     = 1'b0;
    ab_we     = 1'b0;
    aluout_we = 1'b0;
    mdr_we    = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 1'b0;
    case (stateReg)
      IDLE: stateNext = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          stateNext = DECODE;
        end else if (timeoutHit) begin
          stateNext = ERR;
        end
      end
      DECODE: begin
        ab_we = 1'b1;
        case (op_class)
          OP_HALT:    stateNext = HALT;
          OP_ILLEGAL: stateNext = ERR;
          default:    stateNext = EXEC;
        endcase
      end
      EXEC: begin
        case (opReg)
          OP_ALUR, OP_ALUI: begin
            aluout_we = 1'b1;
            stateNext = WB;
          end
          OP_LOAD, OP_STORE: begin
            aluout_we = 1'b1;
            stateNext = MEM;
          end
          OP_BRANCH: begin
            pc_we     = alu_zero;
            pc_src    = 2'd1;
            stateNext = FETCH;
          end
          OP_JUMP: begin
            pc_we     = 1'b1;
            pc_src    = 2'd2;
            stateNext = FETCH;
          end
          default: stateNext = ERR;
        endcase
      end
      MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (opReg == OP_STORE);
        if (mem_ready) begin
          if (opReg == OP_LOAD) begin
            mdr_we    = 1'b1;
            stateNext = WB;
          end else begin
            stateNext = FETCH;
          end
        end else if (timeoutHit) begin
          stateNext = ERR;
        end
      end
      WB: begin
        rf_we     = 1'b1;
        wb_sel    = (opReg == OP_LOAD);
        stateNext = FETCH;
      end
      default: stateNext = stateReg;  // HALT and ERR are absorbing
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stateReg <= IDLE;
    else        stateReg <= stateNext;
  end

  // Latch the instruction class in DECODE; later states look only at this copy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  opReg <= 3'd0;
    else if (stateReg == DECODE) opReg <= op_class;
  end

  // Memory wait counter: cleared on every state change, counts stalled request cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     waitCnt <= '0;
    else if (stateNext != stateReg) waitCnt <= '0;
    else if (mem_req && !mem_ready) waitCnt <= waitCnt + 1'b1;
  end

  // Retired-instruction counter: one count per return to FETCH from a completing state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      retiredReg <= '0;
    else if (stateNext == FETCH && (stateReg inside {EXEC, MEM, WB}))
      retiredReg <= retiredReg + 1'b1;
  end

  assign state   = stateReg;
  assign halted  = (stateReg == HALT);
  assign error   = (stateReg == ERR);
  assign retired = retiredReg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: each instruction is expanded into
// its expected per-cycle trace from the sequencing rules, then replayed.
module tb_multicycle_ctrl;

  localparam int TO = 16;

  localparam logic [11:0] F_MREQ  = 12'h800;
  localparam logic [11:0] F_MWE   = 12'h400;
  localparam logic [11:0] F_IORD  = 12'h200;
  localparam logic [11:0] F_PCWE  = 12'h100;
  localparam logic [11:0] F_SRC2  = 12'h080;
  localparam logic [11:0] F_SRC1  = 12'h040;
  localparam logic [11:0] F_IRWE  = 12'h020;
  localparam logic [11:0] F_ABWE  = 12'h010;
  localparam logic [11:0] F_AOWE  = 12'h008;
  localparam logic [11:0] F_MDRWE = 12'h004;
  localparam logic [11:0] F_RFWE  = 12'h002;
  localparam logic [11:0] F_WBSEL = 12'h001;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
  localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_ERR = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  op_class = 3'd0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, iord, pc_we, ir_we, ab_we, aluout_we, mdr_we, rf_we, wb_sel;
  logic [1:0]  pc_src;
  logic [2:0]  state;
  logic        halted, error;
  logic [31:0] retired;

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op_class(op_class), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .ab_we(ab_we),
    .aluout_we(aluout_we), .mdr_we(mdr_we), .rf_we(rf_we), .wb_sel(wb_sel),
    .state(state), .halted(halted), .error(error), .retired(retired)
  );

  always #5 clk = ~clk;

  logic [16:0] obsVec;
  assign obsVec = {state, mem_req, mem_we, iord, pc_we, pc_src, ir_we, ab_we,
                   aluout_we, mdr_we, rf_we, wb_sel, halted, error};

  typedef struct {
    logic [2:0]  st;
    logic [11:0] fl;
    logic        memReady;
    logic        aluZero;
    logic [2:0]  opc;
    logic [31:0] ret;
  } cycle_t;

  cycle_t      trace[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] modelRetired = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic addCycle(input logic [2:0] st, input logic mr, input logic az,
                          input logic [2:0] opc, input logic [11:0] fl);
    cycle_t c;
    c.st = st; c.fl = fl; c.memReady = mr; c.aluZero = az; c.opc = opc; c.ret = modelRetired;
    trace.push_back(c);
  endtask

  // A cycle whose op_class/alu_zero values must not matter.
  task automatic addFree(input logic [2:0] st, input logic mr, input logic [11:0] fl);
    addCycle(st, mr, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), fl);
  endtask

  task automatic absorb(input logic [2:0] st);
    repeat (3) addFree(st, 1'($urandom_range(0, 1)), 12'h000);
  endtask

  // Request phase: waitN stalled cycles then a ready cycle, or ERR after TO stalls.
  task automatic memPhase(input logic [2:0] st, input logic [11:0] base,
                          input logic [11:0] readyExtra, input int waitN, output bit timedOut);
    if (waitN >= TO) begin
      repeat (TO) addFree(st, 1'b0, base);
      absorb(S_ERR);
      timedOut = 1'b1;
    end else begin
      repeat (waitN) addFree(st, 1'b0, base);
      addFree(st, 1'b1, base | readyExtra);
      timedOut = 1'b0;
    end
  endtask

  // Expected trace of one instruction; done=1 when the machine ends in HALT/ERR.
  task automatic planInstr(input logic [2:0] op, input int fw, input int mw,
                           input logic az, output bit done);
    bit to;
    memPhase(S_FETCH, F_MREQ, F_IRWE | F_PCWE, fw, to);
    done = to;
    if (!done) begin
      addCycle(S_DECODE, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op, F_ABWE);
      if (op == 3'd6) begin
        absorb(S_HALT);
        done = 1'b1;
      end else if (op == 3'd7) begin
        absorb(S_ERR);
        done = 1'b1;
      end else if (op == 3'd4) begin
        addCycle(S_EXEC, 1'($urandom_range(0, 1)), az, 3'($urandom_range(0, 7)),
                 az ? (F_PCWE | F_SRC1) : F_SRC1);
        modelRetired++;
      end else if (op == 3'd5) begin
        addFree(S_EXEC, 1'($urandom_range(0, 1)), F_PCWE | F_SRC2);
        modelRetired++;
      end else begin
        addFree(S_EXEC, 1'($urandom_range(0, 1)), F_AOWE);
        if (op == 3'd2 || op == 3'd3) begin
          memPhase(S_MEM, F_MREQ | F_IORD | ((op == 3'd3) ? F_MWE : 12'h000),
                   (op == 3'd2) ? F_MDRWE : 12'h000, mw, to);
          done = to;
        end
        if (!done && op != 3'd3)
          addFree(S_WB, 1'($urandom_range(0, 1)), F_RFWE | ((op == 3'd2) ? F_WBSEL : 12'h000));
        if (!done) modelRetired++;
      end
    end
  endtask

  // Replay up to 'limit' planned cycles: drive at negedge, sample 1ns later.
  task automatic runTrace(input int limit);
    int n = 0;
    while (trace.size() > 0 && n < limit) begin
      cycle_t c = trace.pop_front();
      mem_ready = c.memReady;
      alu_zero  = c.aluZero;
      op_class  = c.opc;
      #1;
      checkVal($sformatf("cyc%0d outputs st%0d", n, c.st), 32'(obsVec),
               32'({c.st, c.fl, c.st == S_HALT, c.st == S_ERR}));
      checkVal($sformatf("cyc%0d retired", n), retired, c.ret);
      n++;
      @(negedge clk);
    end
    trace.delete();
  endtask

  // Hold reset 3 cycles checking quiet outputs, release at a negedge, queue the IDLE cycle.
  task automatic applyReset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      mem_ready = 1'($urandom_range(0, 1));
      op_class  = 3'($urandom_range(0, 7));
      #1;
      checkVal("reset outputs", 32'(obsVec), 32'd0);
      checkVal("reset retired", retired, 32'd0);
      @(negedge clk);
    end
    reset = 1'b1;
    modelRetired = 0;
    trace.delete();
    addFree(S_IDLE, 1'($urandom_range(0, 1)), 12'h000);
  endtask

  function automatic int pickWait();
    if ($urandom_range(0, 9) < 8) return int'($urandom_range(0, 3));
    return int'($urandom_range(TO - 2, TO + 1));
  endfunction

  initial begin
    bit done;

    // Directed: mixed program with waits, both branch outcomes, ending in HALT.
    applyReset();
    planInstr(3'd0, 0, 0, 1'b0, done);
    planInstr(3'd2, 2, 2, 1'b0, done);
    planInstr(3'd4, 0, 0, 1'b1, done);
    planInstr(3'd4, 0, 0, 1'b0, done);
    planInstr(3'd5, 1, 0, 1'b0, done);
    planInstr(3'd3, 0, 3, 1'b0, done);
    planInstr(3'd1, 0, 0, 1'b0, done);
    planInstr(3'd6, 0, 0, 1'b0, done);
    runTrace(100000);

    // Directed: store that never completes times out.
    applyReset();
    planInstr(3'd3, 0, TO, 1'b0, done);
    runTrace(100000);

    // Directed: ready on the last allowed MEM cycle still completes.
    applyReset();
    planInstr(3'd2, 0, TO - 1, 1'b0, done);
    planInstr(3'd0, TO - 1, 0, 1'b0, done);
    planInstr(3'd0, TO, 0, 1'b0, done);
    runTrace(100000);

    // Directed: illegal opcode.
    applyReset();
    planInstr(3'd7, 0, 0, 1'b0, done);
    runTrace(100000);

    // Directed: reset asserted mid-MEM returns to IDLE immediately.
    applyReset();
    planInstr(3'd3, 0, 10, 1'b0, done);
    runTrace(5);
    mem_ready = 1'b0;
    #1;
    checkVal("midmem state", 32'(state), 32'(S_MEM));
    #1;
    reset = 1'b0;
    #1;
    checkVal("midmem reset outputs", 32'(obsVec), 32'd0);
    checkVal("midmem reset retired", retired, 32'd0);

    // Random programs.
    for (int ep = 0; ep < 40; ep++) begin
      applyReset();
      done = 1'b0;
      for (int k = 0; k < 8 && !done; k++) begin
        logic [2:0] op;
        op = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
        planInstr(op, pickWait(), pickWait(), 1'($urandom_range(0, 1)), done);
      end
      runTrace(100000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
